// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer.
//   stack_op_e : command opcode carried on cmd_op.
//   state_e    : sequencer FSM states.
//   ctrl_t     : bundle of the single-bit registered control outputs.
//   STACK_BASE_DEF / STACK_LIMIT_DEF : default empty / full SP values.
package stack_seq_pkg;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } stack_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DEC  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    INC  = 3'd4,
    RSP  = 3'd5
  } state_e;

  typedef struct packed {
    logic cmd_ready;
    logic sp_pre_dec;
    logic sp_post_inc;
    logic mem_req;
    logic mem_we;
    logic rsp_valid;
    logic err;
  } ctrl_t;

  // SP is full-descending: empty at BASE, one word below BASE after a push.
  localparam logic [31:0] STACK_BASE_DEF  = 32'h0000_1000;
  localparam logic [31:0] STACK_LIMIT_DEF = 32'h0000_0800;

endpackage

// File: rtl/stack_seq.sv
// Stack push/pop sequencer. Turns push/pop commands into an SP strobe and a
// single memory access against an external SP register and memory port.
// Push: DEC (sp_pre_dec) -> WR (write at the new SP).
// Pop : RD (read at SP) -> INC (sp_post_inc) -> RSP (hold data until taken).
// Push at STACK_LIMIT / pop at STACK_BASE is accepted, flagged on err for
// one cycle and otherwise ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_op, cmd_data carry the command
//   sp_value            current SP from the SP register output
//   sp_pre_dec          one-cycle SP decrement strobe (push)
//   sp_post_inc         one-cycle SP increment strobe (pop)
//   mem_req/we/addr/wdata, mem_rdata, mem_ack   memory access port
//   rsp_valid/ready, rsp_data                    popped word handshake
//   err                 one-cycle overflow/underflow pulse
// All outputs are registered.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int              SIZE        = 32,
  parameter logic [SIZE-1:0] STACK_BASE  = SIZE'(STACK_BASE_DEF),
  parameter logic [SIZE-1:0] STACK_LIMIT = SIZE'(STACK_LIMIT_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [SIZE-1:0] cmd_data,
  input  logic [SIZE-1:0] sp_value,
  output logic            sp_pre_dec,
  output logic            sp_post_inc,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_data,
  output logic            err
);

  state_e          state, state_n;
  ctrl_t           ctrl, ctrl_n;
  logic [SIZE-1:0] addr_n, wdata_n, rdata_n;
  logic            accept;

  assign accept = cmd_valid && ctrl.cmd_ready;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n = state;
    ctrl_n  = '0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    rdata_n = rsp_data;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (stack_op_e'(cmd_op) == OP_PUSH) begin
            if (sp_value == STACK_LIMIT) begin
              ctrl_n.err = 1'b1;
            end else begin
              state_n = DEC;
              wdata_n = cmd_data;
            end
          end else begin
            if (sp_value == STACK_BASE) begin
              ctrl_n.err = 1'b1;
            end else begin
              state_n = RD;
              addr_n  = sp_value;
            end
          end
        end
      end
      DEC: begin
        // The SP register decrements on this same edge, so the write address
        // registered here equals the SP value seen during WR.
        state_n = WR;
        addr_n  = sp_value - SIZE'(1);
      end
      WR: begin
        if (mem_ack) state_n = IDLE;
      end
      RD: begin
        if (mem_ack) begin
          rdata_n = mem_rdata;
          state_n = INC;
        end
      end
      INC: state_n = RSP;
      RSP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state and registered with it, so
    // each strobe is high for exactly the cycle spent in its state.
    ctrl_n.cmd_ready   = (state_n == IDLE);
    ctrl_n.sp_pre_dec  = (state_n == DEC);
    ctrl_n.sp_post_inc = (state_n == INC);
    ctrl_n.mem_req     = (state_n == WR) || (state_n == RD);
    ctrl_n.mem_we      = (state_n == WR);
    ctrl_n.rsp_valid   = (state_n == RSP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_n;
      ctrl      <= ctrl_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      rsp_data  <= rdata_n;
    end
  end

  assign cmd_ready   = ctrl.cmd_ready;
  assign sp_pre_dec  = ctrl.sp_pre_dec;
  assign sp_post_inc = ctrl.sp_post_inc;
  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign rsp_valid   = ctrl.rsp_valid;
  assign err         = ctrl.err;

endmodule

// File: tb/tb_stack_seq.sv
// Testbench for stack_seq: supplies the SP register and a memory with
// configurable ack latency, and compares every command against a LIFO model
// (queue of words plus an expected SP value).
module tb_stack_seq;
  import stack_seq_pkg::*;

  localparam logic [31:0] BASE  = STACK_BASE_DEF;
  localparam logic [31:0] LIMIT = STACK_LIMIT_DEF;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_data, sp_value;
  logic        sp_pre_dec, sp_post_inc;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready, err;
  logic [31:0] rsp_data;

  stack_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .sp_value   (sp_value),
    .sp_pre_dec (sp_pre_dec),
    .sp_post_inc(sp_post_inc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // External SP register, with a load port for directed setups.
  logic [31:0] sp;
  logic        sp_load_en;
  logic [31:0] sp_load_val;
  assign sp_value = sp;

  always @(posedge clk) begin
    if (sp_load_en)       sp <= sp_load_val;
    else if (sp_pre_dec)  sp <= sp - 32'd1;
    else if (sp_post_inc) sp <= sp + 32'd1;
  end

  // Cycle monitors.
  int dec_cnt = 0, inc_cnt = 0, err_cnt = 0, req_cnt = 0, overlap_cnt = 0;
  always @(posedge clk) begin
    if (sp_pre_dec)                dec_cnt++;
    if (sp_post_inc)               inc_cnt++;
    if (err)                       err_cnt++;
    if (mem_req)                   req_cnt++;
    if (sp_pre_dec && sp_post_inc) overlap_cnt++;
  end

  // Memory responder: ack after fixed_wait cycles, or a random 0..3 when
  // fixed_wait is negative. Ack is driven for the following rising edge.
  logic [31:0] mem [logic [31:0]];
  int          fixed_wait = -1;
  int          wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_waddr, last_wdata, last_raddr;

  initial begin
    int  wcnt;
    bit  busy;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    busy      = 1'b0;
    wcnt      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem_req || mem_ack) begin
        mem_ack = 1'b0;
        busy    = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
          end else begin
            mem_rdata  = mem.exists(mem_addr) ? mem[mem_addr] : 32'hBAD0_0000;
            rd_cnt++;
            last_raddr = mem_addr;
          end
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Reference model: stack contents and expected SP.
  logic [31:0] model_q[$];
  logic [31:0] model_sp;

  task automatic set_sp(input logic [31:0] v);
    @(negedge clk);
    sp_load_en  = 1'b1;
    sp_load_val = v;
    @(posedge clk);
    #1 sp_load_en = 1'b0;
    @(negedge clk);
    model_sp = v;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check({tag, "_timeout"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Offer a command at a falling edge; returns at the falling edge of the
  // cycle that follows acceptance.
  task automatic issue(input stack_op_e op, input logic [31:0] d);
    wait_ready("issue");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
    @(negedge clk);
  endtask

  task automatic do_push(input logic [31:0] d);
    bit exp_err;
    int d0, i0, e0, r0, w0;
    exp_err = (model_sp == LIMIT);
    d0 = dec_cnt; i0 = inc_cnt; e0 = err_cnt; r0 = req_cnt; w0 = wr_cnt;
    issue(OP_PUSH, d);
    check("push_err_level", {31'd0, err}, {31'd0, exp_err});
    if (exp_err) check("push_err_ready", {31'd0, cmd_ready}, 32'd1);
    else         wait_ready("push_done");
    @(negedge clk);
    check("push_dec_pulses", dec_cnt - d0, exp_err ? 0 : 1);
    check("push_inc_pulses", inc_cnt - i0, 0);
    check("push_err_pulses", err_cnt - e0, exp_err ? 1 : 0);
    check("push_writes", wr_cnt - w0, exp_err ? 0 : 1);
    if (exp_err) begin
      check("push_err_no_req", req_cnt - r0, 0);
    end else begin
      check("push_addr", last_waddr, model_sp - 32'd1);
      check("push_data", last_wdata, d);
      model_sp = model_sp - 32'd1;
      model_q.push_back(d);
    end
    check("push_sp", sp, model_sp);
  endtask

  task automatic do_pop(input int hold);
    bit          exp_err;
    int          d0, i0, e0, r0, rd0, n;
    logic [31:0] got, exp_data;
    exp_err = (model_sp == BASE);
    d0 = dec_cnt; i0 = inc_cnt; e0 = err_cnt; r0 = req_cnt; rd0 = rd_cnt;
    issue(OP_POP, $urandom);
    check("pop_err_level", {31'd0, err}, {31'd0, exp_err});
    if (!exp_err) begin
      n = 0;
      while (!rsp_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("pop_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      got      = rsp_data;
      exp_data = (model_q.size() > 0) ? model_q[$] : 32'hXXXX_XXXX;
      check("pop_data", got, exp_data);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("pop_hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("pop_hold_data", rsp_data, got);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("pop_valid_drop", {31'd0, rsp_valid}, 32'd0);
      wait_ready("pop_done");
    end
    @(negedge clk);
    check("pop_inc_pulses", inc_cnt - i0, exp_err ? 0 : 1);
    check("pop_dec_pulses", dec_cnt - d0, 0);
    check("pop_err_pulses", err_cnt - e0, exp_err ? 1 : 0);
    check("pop_reads", rd_cnt - rd0, exp_err ? 0 : 1);
    if (exp_err) begin
      check("pop_err_no_req", req_cnt - r0, 0);
    end else begin
      check("pop_addr", last_raddr, model_sp);
      model_sp = model_sp + 32'd1;
      if (model_q.size() > 0) void'(model_q.pop_back());
    end
    check("pop_sp", sp, model_sp);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 1'b0;
    cmd_data    = '0;
    rsp_ready   = 1'b0;
    sp_load_en  = 1'b0;
    sp_load_val = '0;
    model_sp    = BASE;

    // Reset state.
    set_sp(BASE);
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_ctrl", {25'd0, sp_pre_dec, sp_post_inc, mem_req, mem_we, rsp_valid, err, 1'b0}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Push with a two-cycle ack delay.
    fixed_wait = 2;
    do_push(32'hDEAD_BEEF);
    check("push_final_sp", sp, 32'h0000_0FFF);

    // Pop a known word with rsp_ready held off for three cycles.
    mem[32'h0000_0FFF] = 32'h1234_5678;
    model_q[model_q.size() - 1] = 32'h1234_5678;
    fixed_wait = 1;
    do_pop(3);
    check("pop_final_sp", sp, BASE);

    // Underflow and overflow.
    do_pop(0);
    set_sp(LIMIT);
    do_push(32'h5555_AAAA);
    set_sp(BASE);

    // Back-to-back with zero-wait ack.
    fixed_wait = 0;
    do_push(32'h0000_0A0A);
    do_push(32'h0000_0B0B);
    do_pop(0);
    do_pop(0);
    check("b2b_final_sp", sp, BASE);

    // Random command mix with random ack and response delays.
    fixed_wait = -1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) do_push($urandom);
      else                           do_pop(int'($urandom_range(0, 3)));
    end

    // Reset while a write is outstanding.
    set_sp(BASE);
    model_q.delete();
    fixed_wait = 8;
    e0 = err_cnt;
    issue(OP_PUSH, 32'hCAFE_F00D);
    begin
      int n = 0;
      while (!mem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("midrst_req_seen", {31'd0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req_drop", {31'd0, mem_req}, 32'd0);
    check("midrst_we_drop", {31'd0, mem_we}, 32'd0);
    check("midrst_dec_low", {31'd0, sp_pre_dec}, 32'd0);
    check("midrst_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_req_idle", {31'd0, mem_req}, 32'd0);
    set_sp(BASE);
    fixed_wait = 0;
    do_push(32'h0BAD_CAFE);
    do_pop(1);

    check("no_strobe_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
